// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: synchronised/filtered ps2_clk, 11-bit frame FSM,
// E0/F0 prefix folding and a first-word-fall-through scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to discard frames with bad (even) parity.
module ps2_frame_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  input  logic                             rd_en,
  input  logic                             clr_err,
  output logic [9:0]                       rd_data,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             err_parity,
  output logic                             err_frame,
  output logic                             err_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_level_q, filt_level_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             fall_edge, clk_s, data_s;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             acc_q, acc_d;
  logic             frame_err_set, par_err_set;

  logic             ext_q, ext_d, brk_q, brk_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [9:0]       rd_data_q, rd_data_d, push_word, head_next;
  logic             push_req, push, pop, ovf_set;
  logic             err_parity_q, err_parity_d, err_frame_q, err_frame_d;
  logic             err_ovf_q, err_ovf_d;
  logic [9:0]       mem [FIFO_DEPTH];

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Level only moves once FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_level_d = filt_level_q;
    flt_cnt_d    = '0;
    fall_edge    = 1'b0;
    if (clk_s != filt_level_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_level_d = clk_s;
        fall_edge    = !clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    par_d         = par_q;
    acc_d         = 1'b0;
    frame_err_set = 1'b0;
    par_err_set   = 1'b0;
    if (state_q == IDLE || fall_edge) tmr_d = '0;
    else                              tmr_d = tmr_q + 1'b1;
    case (state_q)
      IDLE: if (fall_edge && !data_s) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        par_d     = 1'b0;
      end
      DATA: if (fall_edge) begin
        shift_d   = {data_s, shift_q[7:1]};
        par_d     = par_q ^ data_s;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall_edge) begin
        par_d   = par_q ^ data_s;
        state_d = STOP;
      end
      STOP: if (fall_edge) begin
        state_d = IDLE;
        if (!data_s) begin
          frame_err_set = 1'b1;
        end else begin
`ifdef PS2_PARITY_CHECK_EN
          if (!par_q) par_err_set = 1'b1;
          else        acc_d       = 1'b1;
`else
          acc_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !fall_edge && tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      state_d       = IDLE;
      frame_err_set = 1'b1;
    end
  end

  // Accepted byte is still held in shift_q the cycle after the stop bit.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push_req  = 1'b0;
    push_word = {ext_q, brk_q, shift_q};
    if (acc_q) begin
      if (shift_q == 8'hE0)      ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        push_req = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
    pop     = rd_en && (count_q != '0);
    push    = push_req && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    ovf_set = push_req && !push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Bypass when the new head is the word being written this cycle.
    if (push && wr_ptr_q == rd_ptr_d) head_next = push_word;
    else                              head_next = mem[rd_ptr_d];
    rd_data_d = (count_d != '0) ? head_next : rd_data_q;

    err_parity_d = par_err_set   | (err_parity_q & ~clr_err);
    err_frame_d  = frame_err_set | (err_frame_q  & ~clr_err);
    err_ovf_d    = ovf_set       | (err_ovf_q    & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_level_q <= 1'b1;
      flt_cnt_q    <= '0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      tmr_q        <= '0;
      acc_q        <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      filt_level_q <= filt_level_d;
      flt_cnt_q    <= flt_cnt_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      tmr_q        <= tmr_d;
      acc_q        <= acc_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      err_parity_q <= err_parity_d;
      err_frame_q  <= err_frame_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign err_parity   = err_parity_q;
  assign err_frame    = err_frame_q;
  assign err_overflow = err_ovf_q;
endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8; scan-code FIFO entries, power of two, 2..64.
REQ-002 Parameter FILTER_LEN, default 4; consecutive equal samples required to accept a ps2_clk level change.
REQ-003 Parameter TIMEOUT_CYCLES, default 16384; clk cycles without a ps2_clk falling edge before an in-progress frame aborts.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-008 rd_en  input  1  pop FIFO head; ignored when empty.
REQ-009 clr_err  input  1  clears all sticky error flags.
REQ-010 rd_data  output  10  FIFO head: bit9 extended (E0), bit8 break (F0), bits7:0 scan code.
REQ-011 empty  output  1  FIFO holds zero entries.
REQ-012 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 count  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-014 err_parity  output  1  sticky, parity error seen.
REQ-015 err_frame  output  1  sticky, bad stop bit or timeout seen.
REQ-016 err_overflow  output  1  sticky, code dropped because FIFO full.

Function
REQ-017 ps2_clk and ps2_data SHALL each pass a 2-flop synchroniser; synchronised ps2_clk SHALL change filtered level only after FILTER_LEN consecutive equal samples.
REQ-018 A bit SHALL be sampled from synchronised ps2_data on each filtered ps2_clk 1->0 transition.
REQ-019 Frame FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on sampled 0 (start bit), sampled 1 in IDLE ignored.
REQ-020 DATA shifts 8 bits LSB first via 3-bit counter, ->PARITY after 8th bit; PARITY->STOP after one bit; STOP->IDLE after one bit.
REQ-021 Stop bit 0 SHALL discard the byte and set err_frame.
REQ-022 In DATA/PARITY/STOP, TIMEOUT_CYCLES clk cycles without a filtered falling edge SHALL force IDLE, discard partial byte, set err_frame; timer reloads on every edge.
REQ-023 Accepted byte 0xE0 SHALL set pending-ext flag, 0xF0 pending-break flag; neither is pushed.
REQ-024 Any other accepted byte SHALL push {ext,brk,byte} and clear both pending flags in the same cycle.
REQ-025 Push SHALL occur the clk cycle after the stop-bit sample; empty deasserts and rd_data valid the following cycle (first-word-fall-through).
REQ-026 rd_en with !empty SHALL advance head next cycle; rd_data undefined-free: holds last head value when empty.
REQ-027 Push when full and no pop: code dropped, err_overflow set, pending flags still cleared.
REQ-028 Push and pop same cycle: both performed, count unchanged, including when full.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH nor underflows.
REQ-030 clr_err in same cycle as a new error: error wins, flag remains set.

Reset
REQ-031 reset SHALL asynchronously force FSM IDLE, pointers and count 0, empty 1, full 0, rd_data 0, all error and pending flags 0, filter level 1, timeout timer cleared.
REQ-032 Reset mid-frame SHALL discard the partial byte; reception restarts at next start bit after release.

Configuration
REQ-033 Macro PS2_PARITY_CHECK_EN defined: byte with even total parity over data+parity bit SHALL be discarded and err_parity set, pending flags unchanged.
REQ-034 PS2_PARITY_CHECK_EN undefined: parity bit sampled but ignored, err_parity tied 0.

Verification
REQ-035 Frame 0x1C, odd parity, stop 1 -> rd_data=0x01C, count=1, no errors.
REQ-036 Frames E0,F0,75 -> single entry rd_data=0x375; frame 75 alone next -> 0x075.
REQ-037 Frame 0x1C with parity flipped -> with macro: count=0, err_parity=1; without: rd_data=0x01C.
REQ-038 FIFO_DEPTH+1 codes, no reads -> full=1, count=FIFO_DEPTH, err_overflow=1, head is first code; clr_err -> flag 0.
REQ-039 Stop after 4 data bits, wait TIMEOUT_CYCLES+1 -> err_frame=1, FSM IDLE; next valid frame 0x29 -> rd_data=0x029.
REQ-040 1-cycle glitch on ps2_clk (FILTER_LEN=4) -> no bit sampled; reset asserted mid-frame -> all outputs at REQ-031 values.
